// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multicycle RISC-V controller slice:
// branch func3 codes, memory-port FSM states and access kinds.
package riscv_mc_pkg;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_e;

  typedef enum logic {
    FETCH,
    DATA
  } access_kind_e;

endpackage

// File: rtl/mem_fetch_unit_branch_cond.sv
// Combinational branch-condition decoder: func3/zero/neg -> taken.
module branch_cond
  import riscv_mc_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       neg,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (func3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = neg;
      F3_BGE:  taken = ~neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_fetch_unit.sv
// PC/OldPC/IR/MDR owner and unified-memory port with req/ack wait states.
// Optional performance counters are built when MEM_PERF_CNT_EN is defined.
module mem_fetch_unit
  import riscv_mc_pkg::*;
#(
  parameter int unsigned           ADDR_W   = 32,
  parameter int unsigned           DATA_W   = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCUpdate,
  input  logic              branch,
  input  logic [2:0]        func3,
  input  logic              zero,
  input  logic              neg,
  input  logic              IRWrite,
  input  logic              AdrSrc,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] result,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] old_pc,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
);

  mem_state_e        state_q, state_d;
  access_kind_e      kind_q, kind_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] pc_q, old_pc_q;
  logic [DATA_W-1:0] instr_q, mdr_q;
  logic              taken, req, complete;

  branch_cond u_branch_cond (
    .func3 (func3),
    .zero  (zero),
    .neg   (neg),
    .taken (taken)
  );

  // In IDLE the port is driven straight from the request inputs; in WAIT
  // only the latched copy is visible, so inputs may change freely.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    req     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req     = IRWrite | AdrSrc;
        wdata_d = wdata;
        if (IRWrite) begin
          kind_d = FETCH;
          addr_d = pc_q;
          we_d   = 1'b0;
        end else begin
          kind_d = DATA;
          addr_d = result;
          we_d   = AdrSrc & MemWrite;
        end
        if (req && !mem_ack) state_d = WAIT;
      end
      WAIT: begin
        req = 1'b1;
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req   = req;
  assign mem_we    = we_d;
  assign mem_addr  = addr_d;
  assign mem_wdata = wdata_d;
  assign busy      = req & ~mem_ack;
  assign complete  = req & mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      kind_q   <= FETCH;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      pc_q     <= RESET_PC;
      old_pc_q <= '0;
      instr_q  <= '0;
      mdr_q    <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      if (complete && kind_d == FETCH) begin
        instr_q  <= mem_rdata;
        old_pc_q <= pc_q;
      end
      if (complete && kind_d == DATA && !we_d) mdr_q <= mem_rdata;
      if ((PCUpdate && !busy) || (branch && taken)) pc_q <= result;
    end
  end

  assign pc     = pc_q;
  assign old_pc = old_pc_q;
  assign instr  = instr_q;
  assign mdr    = mdr_q;

`ifdef MEM_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (complete && kind_d == FETCH) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (busy) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Directed bench for mem_fetch_unit: hand-written access sequences plus a
// table of branch-condition vectors.
module tb_mem_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, PCUpdate, branch, zero, neg, IRWrite, AdrSrc, MemWrite, mem_ack;
  logic [2:0]  func3;
  logic [31:0] result, wdata, mem_rdata;
  logic        mem_req, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, pc, old_pc, instr, mdr, fetch_cnt, stall_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .PCUpdate(PCUpdate), .branch(branch), .func3(func3),
    .zero(zero), .neg(neg), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .result(result), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .pc(pc), .old_pc(old_pc), .instr(instr), .mdr(mdr),
    .busy(busy), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [2:0] f3;
    logic       z;
    logic       n;
    logic [31:0] exp_pc;
  } br_vec_t;

  br_vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PCUpdate = 0; branch = 0; IRWrite = 0; AdrSrc = 0; MemWrite = 0;
    mem_ack = 0; func3 = 3'b000; zero = 0; neg = 0;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 1'b1, 1'b0, 32'h40};
    vecs[1]  = '{3'b000, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{3'b001, 1'b0, 1'b1, 32'h40};
    vecs[3]  = '{3'b001, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{3'b100, 1'b0, 1'b1, 32'h40};
    vecs[5]  = '{3'b100, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{3'b101, 1'b1, 1'b0, 32'h40};
    vecs[7]  = '{3'b101, 1'b0, 1'b1, 32'h0};
    vecs[8]  = '{3'b010, 1'b1, 1'b1, 32'h0};
    vecs[9]  = '{3'b010, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{3'b011, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{3'b110, 1'b0, 1'b1, 32'h0};
    vecs[12] = '{3'b111, 1'b1, 1'b1, 32'h0};
    vecs[13] = '{3'b000, 1'b1, 1'b1, 32'h40};

    idle_inputs();
    result = 0; wdata = 0; mem_rdata = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("reset_pc", pc, 32'h0);
    chk("reset_old_pc", old_pc, 32'h0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_mdr", mdr, 32'h0);
    chk("reset_req", {31'b0, mem_req}, 32'h0);
    chk("reset_we", {31'b0, mem_we}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_fetch_cnt", fetch_cnt, 32'h0);
    chk("reset_stall_cnt", stall_cnt, 32'h0);

    // Zero-wait fetch
    IRWrite = 1; PCUpdate = 1; result = 32'h4; mem_ack = 1; mem_rdata = 32'h00500093;
    #1;
    chk("zw_req", {31'b0, mem_req}, 32'h1);
    chk("zw_busy", {31'b0, busy}, 32'h0);
    chk("zw_addr", mem_addr, 32'h0);
    tick();
    idle_inputs();
    chk("zw_instr", instr, 32'h00500093);
    chk("zw_old_pc", old_pc, 32'h0);
    chk("zw_pc", pc, 32'h4);

    // Fetch with 3 wait cycles
    IRWrite = 1; PCUpdate = 1; result = 32'h8; mem_rdata = 32'h00A00113;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ws_busy", {31'b0, busy}, 32'h1);
      chk("ws_addr", mem_addr, 32'h4);
      chk("ws_pc", pc, 32'h4);
      tick();
      IRWrite = (i == 0) ? 1'b0 : IRWrite; // held state: request input no longer matters
      result = 32'h8;
    end
    mem_ack = 1;
    #1;
    chk("ws_ack_busy", {31'b0, busy}, 32'h0);
    chk("ws_ack_req", {31'b0, mem_req}, 32'h1);
    tick();
    idle_inputs();
    chk("ws_pc_after", pc, 32'h8);
    chk("ws_instr", instr, 32'h00A00113);
    chk("ws_old_pc", old_pc, 32'h4);
`ifdef MEM_PERF_CNT_EN
    chk("cnt_fetch", fetch_cnt, 32'd2);
    chk("cnt_stall", stall_cnt, 32'd3);
`endif

    // Load with one wait state
    AdrSrc = 1; result = 32'h100;
    #1;
    chk("ld_we", {31'b0, mem_we}, 32'h0);
    chk("ld_addr", mem_addr, 32'h100);
    chk("ld_busy", {31'b0, busy}, 32'h1);
    tick();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_busy_ack", {31'b0, busy}, 32'h0);
    tick();
    idle_inputs();
    chk("ld_mdr", mdr, 32'hDEADBEEF);
    chk("ld_pc", pc, 32'h8);

    // Store; inputs change during WAIT
    AdrSrc = 1; MemWrite = 1; wdata = 32'h55; result = 32'h200;
    #1;
    chk("st_we", {31'b0, mem_we}, 32'h1);
    tick();
    result = 32'h300; wdata = 32'h77; MemWrite = 0; AdrSrc = 0;
    #1;
    chk("st_hold_addr", mem_addr, 32'h200);
    chk("st_hold_wdata", mem_wdata, 32'h55);
    chk("st_hold_we", {31'b0, mem_we}, 32'h1);
    mem_ack = 1; mem_rdata = 32'h12121212;
    tick();
    idle_inputs();
    chk("st_mdr", mdr, 32'hDEADBEEF);
    chk("st_req_idle", {31'b0, mem_req}, 32'h0);

    // Branch-condition table
    for (int i = 0; i < 14; i++) begin
      PCUpdate = 1; result = 32'h0;
      tick();
      PCUpdate = 0; branch = 1; func3 = vecs[i].f3; zero = vecs[i].z; neg = vecs[i].n;
      result = 32'h40;
      tick();
      idle_inputs();
      chk($sformatf("br_%0d_f3_%b_z%b_n%b", i, vecs[i].f3, vecs[i].z, vecs[i].n), pc, vecs[i].exp_pc);
    end

    // Reset during the second WAIT cycle
    PCUpdate = 1; result = 32'h10;
    tick();
    PCUpdate = 0;
    IRWrite = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    tick();
    chk("rw_busy_before", {31'b0, busy}, 32'h1);
    rst = 1; IRWrite = 0;
    tick();
    rst = 0;
    chk("rw_req", {31'b0, mem_req}, 32'h0);
    chk("rw_pc", pc, 32'h0);
    chk("rw_busy", {31'b0, busy}, 32'h0);
    mem_ack = 1;
    #1;
    chk("rw_late_ack_req", {31'b0, mem_req}, 32'h0);
    tick();
    idle_inputs();
    chk("rw_instr", instr, 32'h0);
    chk("rw_fetch_cnt", fetch_cnt, 32'h0);
    chk("rw_stall_cnt", stall_cnt, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
